multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode field width.
REQ-002 Parameter ALUOP_W, default 3, ALU operation code width.
REQ-003 Parameter IRQ_NONE, default 0; reserved, no function.
REQ-004 clk  input  1  sole clock; rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset; all state clears while low.
REQ-006 opcode  input  OPCODE_W  opcode of the instruction register; sampled in DECODE.
REQ-007 mem_ready  input  1  memory handshake; a request completes in the cycle mem_req=1 and mem_ready=1.
REQ-008 cond_true  input  1  datapath branch-condition result, valid in EXEC.
REQ-009 ir_write, pc_write, reg_write, mem_req, mem_we, mem_addr_sel, mem_to_reg, link  output  1 each  datapath strobes and selects.
REQ-010 pc_src  output  2  00 PC+1, 01 branch target, 10 register.
REQ-011 alu_op  output  ALUOP_W; alu_src  output  2  00 reg, 01 immediate, 10 shamt.
REQ-012 instr_done  output  1  one-cycle pulse on instruction retire; halted  output  1  level.

Function
REQ-013 The FSM SHALL use states FETCH, DECODE, EXEC, MEM, WB, HALT; outputs are Moore except mem_req/ir_write/pc_write qualified by mem_ready.
REQ-014 FETCH SHALL hold mem_req=1, mem_addr_sel=0 until mem_ready; on that cycle ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
REQ-015 DECODE SHALL classify opcode: 0 R-type, 1-5 ALU-immediate/shift, 6 lw, 7 sw, 8-10 and 13-14 conditional branch, 11 br, 12 b, 15 bl, 62 nop, 63 halt.
REQ-016 halt SHALL go DECODE->HALT; nop SHALL pulse instr_done and return to FETCH.
REQ-017 R-type and ALU-immediate SHALL traverse EXEC->WB; WB asserts reg_write=1, mem_to_reg=0, instr_done=1.
REQ-018 lw SHALL traverse EXEC->MEM->WB; MEM holds mem_req=1, mem_we=0, mem_addr_sel=1 until mem_ready; WB asserts mem_to_reg=1.
REQ-019 sw SHALL traverse EXEC->MEM; MEM holds mem_req=1, mem_we=1 until mem_ready, then instr_done and FETCH.
REQ-020 Conditional branches SHALL resolve in EXEC: pc_write=cond_true, pc_src=01, instr_done=1, then FETCH.
REQ-021 b/br SHALL write PC unconditionally in EXEC (pc_src 01/10); bl additionally asserts reg_write=1, link=1 in EXEC.
REQ-022 Minimum latency with zero-wait memory: ALU 4 cycles, lw 5, sw 4, branch 3, nop 2.
REQ-023 Every wait cycle (mem_ready=0) SHALL hold all outputs stable; no timeout.
REQ-024 HALT SHALL assert halted=1 and all other strobes 0 until reset.
REQ-025 alu_op/alu_src SHALL be held from decode-table values throughout EXEC, MEM and WB.
REQ-026 Undefined opcodes SHALL behave per REQ-031/REQ-032.

Reset
REQ-027 reset low SHALL force state FETCH and every output to 0, regardless of state or pending mem_req.
REQ-028 First mem_req SHALL assert in the first cycle after reset deasserts.

Configuration
REQ-029 Macro MCU_ILLEGAL_TRAP_EN selects illegal-opcode handling.
REQ-030 An output illegal (1 bit) exists in both builds, tied 0 when the macro is undefined.
REQ-031 Defined: undefined opcode -> HALT with illegal=1 and halted=1.
REQ-032 Undefined: undefined opcode treated as nop (REQ-016).

Structure
REQ-033 Package mcu_pkg SHALL hold the state enum, opcode constants, pc_src/alu_src encodings and the decode-table function.
REQ-034 Sub-module mcu_decode (combinational opcode -> class, alu_op, alu_src) SHALL be instantiated once; the FSM lives in the top module.

Verification
REQ-035 add (op 0), mem_ready=1 -> FETCH,DECODE,EXEC,WB; reg_write=1 only in cycle 4; instr_done pulse at cycle 4.
REQ-036 lw (op 6), mem_ready low 3 cycles in MEM -> outputs stable, mem_to_reg=1 in WB, total 8 cycles.
REQ-037 bz (op 9), cond_true=0 then 1 -> pc_write 0 then 1 in EXEC, pc_src=01, 3 cycles each.
REQ-038 bl (op 15) -> EXEC shows pc_write=1, reg_write=1, link=1.
REQ-039 halt (op 63) -> halted=1 from cycle 3, no further mem_req; reset low mid-MEM of sw -> all outputs 0 immediately, FETCH after release.
REQ-040 opcode 6'b100000 -> with MCU_ILLEGAL_TRAP_EN illegal=1, halted=1; without, instr_done pulse and next FETCH.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle control unit: FSM states,
// instruction classes, opcode map, select encodings and the decode table.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU     = 4'd0,
    CL_LW      = 4'd1,
    CL_SW      = 4'd2,
    CL_BCOND   = 4'd3,
    CL_BR      = 4'd4,
    CL_B       = 4'd5,
    CL_BL      = 4'd6,
    CL_NOP     = 4'd7,
    CL_HALT    = 4'd8,
    CL_ILLEGAL = 4'd9
  } iclass_t;

  // Decode table is indexed on a fixed 8-bit opcode; narrower opcodes are zero-extended.
  localparam int OP_W_MAX = 8;

  localparam logic [7:0] OP_RTYPE = 8'd0;
  localparam logic [7:0] OP_ADDI  = 8'd1;
  localparam logic [7:0] OP_ANDI  = 8'd2;
  localparam logic [7:0] OP_ORI   = 8'd3;
  localparam logic [7:0] OP_SLLI  = 8'd4;
  localparam logic [7:0] OP_SRLI  = 8'd5;
  localparam logic [7:0] OP_LW    = 8'd6;
  localparam logic [7:0] OP_SW    = 8'd7;
  localparam logic [7:0] OP_BEQ   = 8'd8;
  localparam logic [7:0] OP_BZ    = 8'd9;
  localparam logic [7:0] OP_BNE   = 8'd10;
  localparam logic [7:0] OP_BR    = 8'd11;
  localparam logic [7:0] OP_B     = 8'd12;
  localparam logic [7:0] OP_BLT   = 8'd13;
  localparam logic [7:0] OP_BGE   = 8'd14;
  localparam logic [7:0] OP_BL    = 8'd15;
  localparam logic [7:0] OP_NOP   = 8'd62;
  localparam logic [7:0] OP_HALT  = 8'd63;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_REG    = 2'b10;

  localparam logic [1:0] ALU_SRC_REG   = 2'b00;
  localparam logic [1:0] ALU_SRC_IMM   = 2'b01;
  localparam logic [1:0] ALU_SRC_SHAMT = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SLL   = 3'd4;
  localparam logic [2:0] ALU_SRL   = 3'd5;
  localparam logic [2:0] ALU_FUNCT = 3'd7;  // R-type: ALU decodes the funct field

  typedef struct packed {
    iclass_t    iclass;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
  } decode_t;

  // Moore control word held in registers while an instruction is in flight
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(12'h000);

  function automatic decode_t decode_op(input logic [7:0] op);
    decode_t d;
    d.iclass  = CL_ILLEGAL;
    d.alu_op  = ALU_ADD;
    d.alu_src = ALU_SRC_REG;
    case (op)
      OP_RTYPE: begin d.iclass = CL_ALU; d.alu_op = ALU_FUNCT; end
      OP_ADDI:  begin d.iclass = CL_ALU; d.alu_op = ALU_ADD; d.alu_src = ALU_SRC_IMM; end
      OP_ANDI:  begin d.iclass = CL_ALU; d.alu_op = ALU_AND; d.alu_src = ALU_SRC_IMM; end
      OP_ORI:   begin d.iclass = CL_ALU; d.alu_op = ALU_OR;  d.alu_src = ALU_SRC_IMM; end
      OP_SLLI:  begin d.iclass = CL_ALU; d.alu_op = ALU_SLL; d.alu_src = ALU_SRC_SHAMT; end
      OP_SRLI:  begin d.iclass = CL_ALU; d.alu_op = ALU_SRL; d.alu_src = ALU_SRC_SHAMT; end
      OP_LW:    begin d.iclass = CL_LW;  d.alu_src = ALU_SRC_IMM; end
      OP_SW:    begin d.iclass = CL_SW;  d.alu_src = ALU_SRC_IMM; end
      OP_BEQ, OP_BZ, OP_BNE, OP_BLT, OP_BGE:
                begin d.iclass = CL_BCOND; d.alu_op = ALU_SUB; end
      OP_BR:    d.iclass = CL_BR;
      OP_B:     begin d.iclass = CL_B;  d.alu_src = ALU_SRC_IMM; end
      OP_BL:    begin d.iclass = CL_BL; d.alu_src = ALU_SRC_IMM; end
      OP_NOP:   d.iclass = CL_NOP;
      OP_HALT:  d.iclass = CL_HALT;
      default:  d.iclass = CL_ILLEGAL;
    endcase
    return d;
  endfunction

  // Control word presented during EXEC for a freshly decoded instruction
  function automatic ctrl_t exec_ctrl(input iclass_t c, input logic [2:0] aop,
                                      input logic [1:0] asrc);
    ctrl_t k;
    k         = CTRL_IDLE;
    k.alu_op  = aop;
    k.alu_src = asrc;
    case (c)
      CL_BCOND, CL_B: k.pc_src = PC_SRC_BRANCH;
      CL_BR:          k.pc_src = PC_SRC_REG;
      CL_BL: begin
        k.pc_src    = PC_SRC_BRANCH;
        k.reg_write = 1'b1;
        k.link      = 1'b1;
      end
      default:        k.pc_src = PC_SRC_INC;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle: the controller is the master, the datapath the slave.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                cond_true;
  logic                ir_write;
  logic                pc_write;
  logic                reg_write;
  logic                mem_req;
  logic                mem_we;
  logic                mem_addr_sel;
  logic                mem_to_reg;
  logic                link;
  logic [1:0]          pc_src;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          alu_src;
  logic                instr_done;
  logic                halted;
  logic                illegal;

  modport master (
    input  opcode, mem_ready, cond_true,
    output ir_write, pc_write, reg_write, mem_req, mem_we, mem_addr_sel,
           mem_to_reg, link, pc_src, alu_op, alu_src, instr_done, halted, illegal
  );

  modport slave (
    output opcode, mem_ready, cond_true,
    input  ir_write, pc_write, reg_write, mem_req, mem_we, mem_addr_sel,
           mem_to_reg, link, pc_src, alu_op, alu_src, instr_done, halted, illegal
  );
endinterface

// File: rtl/mcu_decode.sv
// Combinational opcode classifier: instruction class plus ALU op/source.
module mcu_decode
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             iclass,
  output logic [2:0]          alu_op,
  output logic [1:0]          alu_src
);

  decode_t dec_s;

  // Widen the opcode onto the table width and look it up
  always_comb begin
    dec_s = decode_op(OP_W_MAX'(opcode));
  end

  assign iclass  = dec_s.iclass;
  assign alu_op  = dec_s.alu_op;
  assign alu_src = dec_s.alu_src;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Select lines are registered Moore outputs; mem_req, ir_write, pc_write and
// instr_done are decoded from the state and qualified by mem_ready/cond_true.
// Build option: define MCU_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT
// with illegal=1; otherwise they retire like a nop and illegal stays 0.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int IRQ_NONE = 0
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_unit_if.master bus
);

  // IRQ_NONE is reserved and has no function in this design.
  if (IRQ_NONE != 0) begin : g_irq_reserved
  end

`ifdef MCU_ILLEGAL_TRAP_EN
  localparam logic ILLEGAL_AS_NOP = 1'b0;
  logic    illegal_r;
`else
  localparam logic ILLEGAL_AS_NOP = 1'b1;
`endif

  state_t     state_r;
  iclass_t    iclass_r;
  ctrl_t      ctrl_r;
  logic       halted_r;

  iclass_t    dec_class_s;
  logic [2:0] dec_alu_op_s;
  logic [1:0] dec_alu_src_s;

  logic       mem_req_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       instr_done_s;

  mcu_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode  (bus.opcode),
    .iclass  (dec_class_s),
    .alu_op  (dec_alu_op_s),
    .alu_src (dec_alu_src_s)
  );

  // State sequencing and the registered Moore control word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_FETCH;
      iclass_r <= CL_NOP;
      ctrl_r   <= CTRL_IDLE;
      halted_r <= 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
      illegal_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_FETCH: begin
          if (bus.mem_ready) state_r <= S_DECODE;
          else               state_r <= S_FETCH;
        end
        S_DECODE: begin
          case (dec_class_s)
            CL_HALT: begin
              state_r  <= S_HALT;
              halted_r <= 1'b1;
            end
            CL_NOP: state_r <= S_FETCH;
`ifdef MCU_ILLEGAL_TRAP_EN
            CL_ILLEGAL: begin
              state_r   <= S_HALT;
              halted_r  <= 1'b1;
              illegal_r <= 1'b1;
            end
`else
            CL_ILLEGAL: state_r <= S_FETCH;
`endif
            default: begin
              state_r  <= S_EXEC;
              iclass_r <= dec_class_s;
              ctrl_r   <= exec_ctrl(dec_class_s, dec_alu_op_s, dec_alu_src_s);
            end
          endcase
        end
        S_EXEC: begin
          case (iclass_r)
            CL_ALU: begin
              state_r           <= S_WB;
              ctrl_r.reg_write  <= 1'b1;
              ctrl_r.mem_to_reg <= 1'b0;
            end
            CL_LW: begin
              state_r             <= S_MEM;
              ctrl_r.mem_addr_sel <= 1'b1;
              ctrl_r.mem_we       <= 1'b0;
            end
            CL_SW: begin
              state_r             <= S_MEM;
              ctrl_r.mem_addr_sel <= 1'b1;
              ctrl_r.mem_we       <= 1'b1;
            end
            default: begin
              state_r <= S_FETCH;
              ctrl_r  <= CTRL_IDLE;
            end
          endcase
        end
        S_MEM: begin
          if (!bus.mem_ready) begin
            state_r <= S_MEM;
          end else if (iclass_r == CL_LW) begin
            state_r             <= S_WB;
            ctrl_r.reg_write    <= 1'b1;
            ctrl_r.mem_to_reg   <= 1'b1;
            ctrl_r.mem_addr_sel <= 1'b0;
          end else begin
            state_r <= S_FETCH;
            ctrl_r  <= CTRL_IDLE;
          end
        end
        S_WB: begin
          state_r <= S_FETCH;
          ctrl_r  <= CTRL_IDLE;
        end
        S_HALT: state_r <= S_HALT;
        default: begin
          state_r <= S_FETCH;
          ctrl_r  <= CTRL_IDLE;
        end
      endcase
    end
  end

  // Handshake-qualified strobes; mem_req is gated by reset so FETCH requests
  // as soon as reset is released
  always_comb begin
    mem_req_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    instr_done_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s  = reset;
        ir_write_s = reset & bus.mem_ready;
        pc_write_s = reset & bus.mem_ready;
      end
      S_DECODE: begin
        if (dec_class_s == CL_NOP)          instr_done_s = 1'b1;
        else if (dec_class_s == CL_ILLEGAL) instr_done_s = ILLEGAL_AS_NOP;
        else                                instr_done_s = 1'b0;
      end
      S_EXEC: begin
        case (iclass_r)
          CL_BCOND: begin
            pc_write_s   = bus.cond_true;
            instr_done_s = 1'b1;
          end
          CL_BR, CL_B, CL_BL: begin
            pc_write_s   = 1'b1;
            instr_done_s = 1'b1;
          end
          default: begin
            pc_write_s   = 1'b0;
            instr_done_s = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        if (iclass_r == CL_SW) instr_done_s = bus.mem_ready;
        else                   instr_done_s = 1'b0;
      end
      S_WB:    instr_done_s = 1'b1;
      default: instr_done_s = 1'b0;
    endcase
  end

  assign bus.mem_req      = mem_req_s;
  assign bus.ir_write     = ir_write_s;
  assign bus.pc_write     = pc_write_s;
  assign bus.instr_done   = instr_done_s;
  assign bus.reg_write    = ctrl_r.reg_write;
  assign bus.mem_to_reg   = ctrl_r.mem_to_reg;
  assign bus.link         = ctrl_r.link;
  assign bus.mem_we       = ctrl_r.mem_we;
  assign bus.mem_addr_sel = ctrl_r.mem_addr_sel;
  assign bus.pc_src       = ctrl_r.pc_src;
  assign bus.alu_op       = ALUOP_W'(ctrl_r.alu_op);
  assign bus.alu_src      = ctrl_r.alu_src;
  assign bus.halted       = halted_r;
`ifdef MCU_ILLEGAL_TRAP_EN
  assign bus.illegal      = illegal_r;
`else
  assign bus.illegal      = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each scenario queues per-cycle
// stimulus and expected outputs, then replays them and compares cycle by cycle.
module tb_multicycle_control_unit;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        cnd;
    logic [17:0] exp;
    string       tag;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  ent_t sb[$];

  logic [17:0] e_fr;  // FETCH, memory ready
  logic [17:0] e_fw;  // FETCH, waiting
  logic [17:0] e_z;   // all outputs low

  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(3)) ifc ();

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .IRQ_NONE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  // {ir_write,pc_write,reg_write,mem_req,mem_we,mem_addr_sel,mem_to_reg,link,
  //  pc_src,alu_op,alu_src,instr_done,halted,illegal}
  function automatic logic [17:0] ov(input logic irw, pcw, rw, mreq, mwe, masel, m2r, lnk,
                                     input logic [1:0] pcs, input logic [2:0] aop,
                                     input logic [1:0] asrc, input logic done, hlt, ill);
    return {irw, pcw, rw, mreq, mwe, masel, m2r, lnk, pcs, aop, asrc, done, hlt, ill};
  endfunction

  function automatic logic [17:0] ex(input logic pcw, rw, lnk, input logic [1:0] pcs,
                                     input logic [2:0] aop, input logic [1:0] asrc,
                                     input logic done);
    return ov(1'b0, pcw, rw, 1'b0, 1'b0, 1'b0, 1'b0, lnk, pcs, aop, asrc, done, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] mm(input logic we, input logic [2:0] aop,
                                     input logic [1:0] asrc, input logic done);
    return ov(1'b0, 1'b0, 1'b0, 1'b1, we, 1'b1, 1'b0, 1'b0, 2'b00, aop, asrc, done, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] wb(input logic m2r, input logic [2:0] aop,
                                     input logic [1:0] asrc);
    return ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m2r, 1'b0, 2'b00, aop, asrc, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] outs();
    return {ifc.ir_write, ifc.pc_write, ifc.reg_write, ifc.mem_req, ifc.mem_we,
            ifc.mem_addr_sel, ifc.mem_to_reg, ifc.link, ifc.pc_src, ifc.alu_op,
            ifc.alu_src, ifc.instr_done, ifc.halted, ifc.illegal};
  endfunction

  task automatic push(input logic [5:0] op, input logic rdy, input logic cnd,
                      input logic [17:0] e, input string tag);
    ent_t x;
    x.op = op; x.rdy = rdy; x.cnd = cnd; x.exp = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic push_fd(input logic [5:0] op, input string tag);
    push(op, 1'b1, 1'b0, e_fr, {tag, "_fetch"});
    push(op, 1'b1, 1'b0, e_z,  {tag, "_decode"});
  endtask

  // Drive one cycle of stimulus after the falling edge and sample outputs
  task automatic step(input ent_t x, output logic [17:0] act);
    @(negedge clk);
    ifc.opcode    = x.op;
    ifc.mem_ready = x.rdy;
    ifc.cond_true = x.cnd;
    #1;
    act = outs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [17:0] act;
    ifc.opcode = 6'd0; ifc.mem_ready = 1'b1; ifc.cond_true = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 act = outs();
    checks++;
    if (act !== e_z) begin
      failures++;
      $display("FAIL reset_hold: got %b expected %b", act, e_z);
    end
    ifc.mem_ready = 1'b0;
    #1 reset = 1'b1;
    #1 act = outs();
    checks++;
    if (act !== e_fw) begin
      failures++;
      $display("FAIL first_mem_req: got %b expected %b", act, e_fw);
    end
  endtask

  task automatic test_alu();
    ent_t x; logic [17:0] act;
    push_fd(6'd0, "add");
    push(6'd0, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd7, 2'b00, 1'b0), "add_exec");
    push(6'd0, 1'b1, 1'b0, wb(1'b0, 3'd7, 2'b00), "add_wb");
    push_fd(6'd4, "slli");
    push(6'd4, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd4, 2'b10, 1'b0), "slli_exec");
    push(6'd4, 1'b0, 1'b0, wb(1'b0, 3'd4, 2'b10), "slli_wb");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_lw();
    ent_t x; logic [17:0] act;
    push_fd(6'd6, "lw");
    push(6'd6, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b01, 1'b0), "lw_exec");
    for (int i = 0; i < 3; i++) push(6'd6, 1'b0, 1'b0, mm(1'b0, 3'd0, 2'b01, 1'b0), "lw_mem_wait");
    push(6'd6, 1'b1, 1'b0, mm(1'b0, 3'd0, 2'b01, 1'b0), "lw_mem_ready");
    push(6'd6, 1'b1, 1'b0, wb(1'b1, 3'd0, 2'b01), "lw_wb");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_sw();
    ent_t x; logic [17:0] act;
    push(6'd7, 1'b0, 1'b0, e_fw, "sw_fetch_wait");
    push(6'd7, 1'b0, 1'b0, e_fw, "sw_fetch_wait");
    push_fd(6'd7, "sw");
    push(6'd7, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b01, 1'b0), "sw_exec");
    push(6'd7, 1'b0, 1'b0, mm(1'b1, 3'd0, 2'b01, 1'b0), "sw_mem_wait");
    push(6'd7, 1'b1, 1'b0, mm(1'b1, 3'd0, 2'b01, 1'b1), "sw_mem_ready");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_branch();
    ent_t x; logic [17:0] act;
    push_fd(6'd9, "bz_nt");
    push(6'd9, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b01, 3'd1, 2'b00, 1'b1), "bz_exec_not_taken");
    push_fd(6'd9, "bz_t");
    push(6'd9, 1'b1, 1'b1, ex(1'b1, 1'b0, 1'b0, 2'b01, 3'd1, 2'b00, 1'b1), "bz_exec_taken");
    push_fd(6'd13, "blt");
    push(6'd13, 1'b0, 1'b1, ex(1'b1, 1'b0, 1'b0, 2'b01, 3'd1, 2'b00, 1'b1), "blt_exec_taken");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_jump();
    ent_t x; logic [17:0] act;
    push_fd(6'd12, "b");
    push(6'd12, 1'b1, 1'b0, ex(1'b1, 1'b0, 1'b0, 2'b01, 3'd0, 2'b01, 1'b1), "b_exec");
    push_fd(6'd11, "br");
    push(6'd11, 1'b1, 1'b0, ex(1'b1, 1'b0, 1'b0, 2'b10, 3'd0, 2'b00, 1'b1), "br_exec");
    push_fd(6'd15, "bl");
    push(6'd15, 1'b1, 1'b0, ex(1'b1, 1'b1, 1'b1, 2'b01, 3'd0, 2'b01, 1'b1), "bl_exec");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_back_to_back();
    ent_t x; logic [17:0] act;
    for (int i = 0; i < 2; i++) begin
      push(6'd62, 1'b1, 1'b0, e_fr, "nop_fetch");
      push(6'd62, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 1'b1), "nop_decode");
    end
    push(6'd0, 1'b0, 1'b0, e_fw, "after_nop_fetch");
    push(6'd0, 1'b1, 1'b0, e_fr, "add2_fetch");
    push(6'd0, 1'b1, 1'b0, e_z,  "add2_decode");
    push(6'd0, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd7, 2'b00, 1'b0), "add2_exec");
    push(6'd0, 1'b1, 1'b0, wb(1'b0, 3'd7, 2'b00), "add2_wb");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_halt();
    ent_t x; logic [17:0] act;
    push_fd(6'd63, "halt");
    for (int i = 0; i < 4; i++)
      push(6'd63, 1'b1, 1'b1, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                 3'd0, 2'b00, 1'b0, 1'b1, 1'b0), "halt_state");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_reset_mid_sw();
    ent_t x; logic [17:0] act;
    do_reset();
    push_fd(6'd7, "sw2");
    push(6'd7, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b01, 1'b0), "sw2_exec");
    push(6'd7, 1'b0, 1'b0, mm(1'b1, 3'd0, 2'b01, 1'b0), "sw2_mem_wait");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
    #1 reset = 1'b0;
    #1 act = outs();
    checks++;
    if (act !== e_z) begin
      failures++;
      $display("FAIL reset_mid_mem: got %b expected %b", act, e_z);
    end
    ifc.mem_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    push(6'd62, 1'b0, 1'b0, e_fw, "post_reset_fetch_wait");
    push(6'd62, 1'b1, 1'b0, e_fr, "post_reset_fetch");
    push(6'd62, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 1'b1), "post_reset_nop");
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  task automatic test_illegal();
    ent_t x; logic [17:0] act;
`ifdef MCU_ILLEGAL_TRAP_EN
    push_fd(6'h20, "illegal");
    for (int i = 0; i < 2; i++)
      push(6'h20, 1'b1, 1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                 3'd0, 2'b00, 1'b0, 1'b1, 1'b1), "illegal_trap");
`else
    for (int i = 0; i < 2; i++) begin
      push(6'h20, 1'b1, 1'b0, e_fr, "illegal_fetch");
      push(6'h20, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 1'b1), "illegal_as_nop");
    end
`endif
    while (sb.size() != 0) begin
      x = sb.pop_front(); step(x, act); checks++;
      if (act !== x.exp) begin failures++; $display("FAIL %s: got %b expected %b", x.tag, act, x.exp); end
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scenario sequence and summary
  initial begin
    e_z  = 18'd0;
    e_fw = ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    e_fr = ov(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_back_to_back();
    test_halt();
    test_reset_mid_sw();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
